sprite_dma: RTL and testbench

Object-RAM-to-shadow-buffer copier that sits directly downstream of the CPU-side sprite RAM. On a CPU DMA request it waits for vertical blank, then reads all 512 sprite words through the sprite RAM's second port and copies them into an internal 512×16 shadow buffer. The sprite scanner reads only the shadow buffer, so CPU writes during active display never tear the displayed object list.

---
 rtl/sprite_dma.sv | 110 +++++++++++
 tb/tb_sprite_dma.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dma.sv
// Sprite RAM to shadow buffer copier: on a CPU request it waits for vertical blank, then
// copies all 512 sprite words so the scanner never sees a half-updated object list.
module sprite_dma (
    input  logic        CLK_32M,
    input  logic        RESET,
    input  logic        DMA_REQ,
    input  logic        VBLANK,
    output logic [8:0]  SRC_ADDR,
    input  logic [15:0] SRC_DATA,
    input  logic [8:0]  OBJ_ADDR,
    output logic [15:0] OBJ_DATA,
    output logic        BUSY,
    output logic        DONE
);
    // state | meaning
    // IDLE  | waiting for a pending request while VBLANK is high
    // COPY  | issuing source addresses 0..511, one per cycle
    // FLUSH | two cycles letting the RAM read pipeline drain into the shadow
    typedef enum logic [1:0] {IDLE, COPY, FLUSH} state_t;

    state_t      state, state_nx;
    logic        req_q;
    logic        pending, pending_nx;
    logic [8:0]  count, count_nx;
    logic        flush_cnt, flush_cnt_nx;
    logic        done_nx;
    logic        start;
    logic        rise;
    logic [8:0]  addr_d1, addr_d2;
    logic        vld_d1, vld_d2;
    logic [15:0] shadow [512];

    assign rise     = DMA_REQ & ~req_q;
    assign BUSY     = (state != IDLE);
    assign SRC_ADDR = count;

    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            pending   <= 1'b0;
            count     <= '0;
            flush_cnt <= 1'b0;
            DONE      <= 1'b0;
            vld_d1    <= 1'b0;
            vld_d2    <= 1'b0;
            addr_d1   <= '0;
            addr_d2   <= '0;
        end else begin
            state     <= state_nx;
            req_q     <= DMA_REQ;
            pending   <= pending_nx;
            count     <= count_nx;
            flush_cnt <= flush_cnt_nx;
            DONE      <= done_nx;
            vld_d1    <= (state == COPY);
            addr_d1   <= count;
            vld_d2    <= vld_d1;
            addr_d2   <= addr_d1;
        end
    end

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        flush_cnt_nx = flush_cnt;
        done_nx      = 1'b0;
        start        = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending && VBLANK) begin
                    state_nx = COPY;
                    count_nx = '0;
                    start    = 1'b1;
                end
            end
            COPY: begin
                // wraps back to 0 after 511, leaving SRC_ADDR at 0 for FLUSH and IDLE
                count_nx = count + 9'd1;
                if (count == 9'd511) begin
                    state_nx     = FLUSH;
                    flush_cnt_nx = 1'b0;
                end
            end
            FLUSH: begin
                flush_cnt_nx = 1'b1;
                if (flush_cnt) begin
                    state_nx     = IDLE;
                    flush_cnt_nx = 1'b0;
                    done_nx      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // a new edge wins over the clear so a request landing on the start edge is kept
        pending_nx = rise | (pending & ~start);
    end

    always_ff @(posedge CLK_32M) begin
        if (vld_d2)
            shadow[addr_d2] <= SRC_DATA;
    end

    always_ff @(posedge CLK_32M or posedge RESET) begin
        if (RESET)
            OBJ_DATA <= '0;
        else
            OBJ_DATA <= shadow[OBJ_ADDR];
    end
endmodule

// File: tb/tb_sprite_dma.sv
// Bench for sprite_dma: table-driven copy scenarios plus hand-written re-request and
// reset-mid-copy sequences, checked against a snapshot model of the shadow buffer.
module tb_sprite_dma;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dma_req = 1'b0;
    logic        vblank = 1'b0;
    logic [8:0]  src_addr;
    logic [15:0] src_data = '0;
    logic [8:0]  obj_addr = '0;
    logic [15:0] obj_data;
    logic        busy, done;

    logic [15:0] sram   [512];
    logic [15:0] exp_sh [512];
    logic [8:0]  ram_a = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int vb_low;
        int drop_at;
        bit pattern;
        int exp_lat;
        int exp_len;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    sprite_dma dut (
        .CLK_32M (clk),
        .RESET   (rst),
        .DMA_REQ (dma_req),
        .VBLANK  (vblank),
        .SRC_ADDR(src_addr),
        .SRC_DATA(src_data),
        .OBJ_ADDR(obj_addr),
        .OBJ_DATA(obj_data),
        .BUSY    (busy),
        .DONE    (done)
    );

    // sprite RAM port B: registered address, registered output
    always @(posedge clk) begin
        ram_a    <= src_addr;
        src_data <= sram[ram_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int mode, input logic [15:0] val);
        for (int i = 0; i < 512; i++) begin
            if (mode == 0)      sram[i] = 16'(i) ^ 16'hA5A5;
            else if (mode == 1) sram[i] = val;
            else                sram[i] = 16'($urandom);
        end
    endtask

    task automatic snapshot();
        for (int i = 0; i < 512; i++) exp_sh[i] = sram[i];
    endtask

    // Raises DMA_REQ, optionally holds VBLANK low, returns at the first BUSY cycle.
    task automatic start_copy(input int vb_low, input int exp_lat);
        int lat;
        bit early;
        early   = 1'b0;
        vblank  = (vb_low == 0);
        dma_req = 1'b1;
        for (int k = 0; k < vb_low; k++) begin
            @(negedge clk);
            dma_req = 1'b0;
            if (busy) early = 1'b1;
        end
        if (vb_low > 0) begin
            check("busy_before_vblank", 32'(early), 32'd0);
            vblank = 1'b1;
        end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            dma_req = 1'b0;
            lat++;
            if (busy) break;
        end
        check("start_latency", lat, exp_lat);
        snapshot();
    endtask

    // Runs from the first BUSY cycle to one cycle past DONE.
    task automatic run_copy(input int drop_at, input bit rereq, input bit refill, input int exp_len);
        int len, dones, bad_addr;
        len = 0; dones = 0; bad_addr = 0;
        while (busy === 1'b1 && len < 1000) begin
            len++;
            if (done) dones++;
            if (len <= 512 && src_addr !== 9'(len - 1)) bad_addr++;
            if (len == drop_at) vblank = 1'b0;
            dma_req = rereq && (len == 10 || len == 20);
            @(negedge clk);
        end
        check("busy_len", len, exp_len);
        check("src_addr_seq", bad_addr, 0);
        check("done_during_busy", dones, 0);
        check("done_pulse", 32'(done), 32'd1);
        if (refill) begin
            fill(2, 16'h0);
            snapshot();
        end
        dma_req = 1'b0;
        vblank  = 1'b1;
        @(negedge clk);
        check("done_width", 32'(done), 32'd0);
    endtask

    task automatic readback(input string name);
        for (int i = 0; i < 512; i++) begin
            obj_addr = 9'(i);
            @(negedge clk);
            check(name, obj_data, exp_sh[i]);
        end
    endtask

    initial begin
        int idle_busy, dones;
        logic [8:0] a;

        vecs[0] = '{vb_low: 0,   drop_at: 0,   pattern: 1'b1, exp_lat: 2, exp_len: 514};
        vecs[1] = '{vb_low: 100, drop_at: 0,   pattern: 1'b0, exp_lat: 1, exp_len: 514};
        vecs[2] = '{vb_low: 0,   drop_at: 200, pattern: 1'b0, exp_lat: 2, exp_len: 514};
        vecs[3] = '{vb_low: 7,   drop_at: 0,   pattern: 1'b0, exp_lat: 1, exp_len: 514};
        vecs[4] = '{vb_low: 1,   drop_at: 300, pattern: 1'b0, exp_lat: 1, exp_len: 514};

        fill(0, 16'h0);
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_src_addr", 32'(src_addr), 32'd0);
        check("reset_obj_data", 32'(obj_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].pattern ? 0 : 2, 16'h0);
            start_copy(vecs[v].vb_low, vecs[v].exp_lat);
            run_copy(vecs[v].drop_at, 1'b0, 1'b0, vecs[v].exp_len);
            readback("readback");
        end

        for (int k = 0; k < 64; k++) begin
            a = 9'($urandom_range(511, 0));
            obj_addr = a;
            @(negedge clk);
            check("random_read", obj_data, exp_sh[a]);
        end

        // two edges during a copy give exactly one extra copy of the refreshed RAM
        fill(2, 16'h0);
        start_copy(0, 2);
        run_copy(0, 1'b1, 1'b1, 514);
        check("second_copy_start", 32'(busy), 32'd1);
        run_copy(0, 1'b0, 1'b0, 514);
        idle_busy = 0;
        repeat (20) begin
            if (busy) idle_busy++;
            @(negedge clk);
        end
        check("no_third_copy", idle_busy, 0);
        readback("rereq_readback");

        // reset in copy cycle 100 leaves a 97-word prefix of new data
        fill(1, 16'h1111);
        start_copy(0, 2);
        run_copy(0, 1'b0, 1'b0, 514);
        fill(1, 16'h2222);
        obj_addr = 9'd300;
        start_copy(0, 2);
        repeat (99) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_obj_data", obj_data, 16'h1111);
        #2 rst = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_src_addr", 32'(src_addr), 32'd0);
        check("async_reset_obj_data", 32'(obj_data), 32'd0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("no_done_after_reset", dones, 0);
        for (int i = 0; i < 512; i++) exp_sh[i] = (i < 97) ? 16'h2222 : 16'h1111;
        readback("reset_prefix");

        fill(2, 16'h0);
        start_copy(0, 2);
        run_copy(0, 1'b0, 1'b0, 514);
        readback("post_reset_copy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
